// File: rtl/pwm_duty_sequencer_if.sv
// Command channel of the PWM duty sequencer: a target duty value offered
// over a valid/ready handshake.
interface pwm_duty_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic [WIDTH-1:0] cmd_duty;
    logic             cmd_ready;

    modport master (output cmd_valid, cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, cmd_duty, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM generator's live duty value toward a commanded target in fixed
// steps, updating only on PWM period boundaries; kill forces duty to zero.
module pwm_duty_sequencer #(
    parameter int WIDTH = 8,
    parameter int STEP  = 4,
    parameter int DIV   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_duty_sequencer_if.slave  cmd,
    input  logic                 period_end,
    input  logic                 kill,
    output logic [WIDTH-1:0]     duty_cycle,
    output logic                 busy,
    output logic                 done
);
    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] target, target_n, duty_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic             done_n;
    logic [WIDTH:0]   gap;
    logic [WIDTH-1:0] step_val;

    assign busy          = (state != IDLE);
    assign cmd.cmd_ready = (state == IDLE) && !kill;

    // Distance to target is taken one bit wider so a full step never wraps.
    always_comb begin
        if (state == DOWN) begin
            gap = {1'b0, duty_cycle} - {1'b0, target};
        end else begin
            gap = {1'b0, target} - {1'b0, duty_cycle};
        end
        if (gap <= STEP_EXT) begin
            step_val = target;
        end else if (state == DOWN) begin
            step_val = duty_cycle - STEP_W;
        end else begin
            step_val = duty_cycle + STEP_W;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_n  = state;
        duty_n   = duty_cycle;
        target_n = target;
        div_n    = div_cnt;
        done_n   = 1'b0;

        if (kill) begin
            state_n  = IDLE;
            duty_n   = '0;
            target_n = '0;
            div_n    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    div_n = '0;
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        target_n = cmd.cmd_duty;
                        if (cmd.cmd_duty > duty_cycle) begin
                            state_n = UP;
                        end else if (cmd.cmd_duty < duty_cycle) begin
                            state_n = DOWN;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                UP, DOWN: begin
                    if (period_end) begin
                        if (div_cnt == DIV_LAST) begin
                            div_n  = '0;
                            duty_n = step_val;
                            if (step_val == target) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            div_n = div_cnt + DIV_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            duty_cycle <= '0;
            target     <= '0;
            div_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            target     <= target_n;
            div_cnt    <= div_n;
            done       <= done_n;
        end
    end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer (WIDTH=8, STEP=4, DIV=2): a table
// of chained ramps plus hand-written kill, hold, equal-command and reset cases.
module tb_pwm_duty_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       period_end;
    logic       kill;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    pwm_duty_sequencer_if #(.WIDTH(8)) cmd_bus ();

    pwm_duty_sequencer #(.WIDTH(8), .STEP(4), .DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_bus),
        .period_end (period_end),
        .kill       (kill),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        int         steps;
        int         pulses;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] prev_duty = 8'd0;
    int         checks    = 0;
    int         errors    = 0;
    int         pe_cnt    = 0;
    int         done_cnt  = 0;
    int         chg_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected duty sequence from the step rule: +-4 per step, clamped to target.
    task automatic push_ramp(input int from, input int to);
        int v;
        v = from;
        while (v != to) begin
            if (to > v) v = (to - v <= 4) ? to : v + 4;
            else        v = (v - to <= 4) ? to : v - 4;
            exp_q.push_back(8'(v));
        end
    endtask

    // One clock; sample 1 ns after the edge and score any duty change.
    task automatic tick();
        logic pe_was, kill_was;
        pe_was   = period_end;
        kill_was = kill;
        @(posedge clk);
        #1;
        if (pe_was) pe_cnt++;
        if (done) done_cnt++;
        if (duty_cycle !== prev_duty) begin
            chg_cnt++;
            check("change_at_boundary", 32'(pe_was | kill_was), 1);
            if (exp_q.size() == 0) check("unexpected_duty_change", duty_cycle, prev_duty);
            else                   check("duty_step", duty_cycle, exp_q.pop_front());
            prev_duty = duty_cycle;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [7:0] d);
        int n;
        n = 0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty  = d;
        while (!cmd_bus.cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check("cmd_accept_timeout", 32'(n < 1000), 1);
        tick();
        cmd_bus.cmd_valid = 1'b0;
    endtask

    // Drive a period_end pulse every third cycle until done, then score the ramp.
    task automatic run_ramp(input int final_v, input int exp_steps, input int exp_pulses,
                            input string tag);
        int c, busy_low, ready_busy;
        c = 0; busy_low = 0; ready_busy = 0;
        pe_cnt = 0; done_cnt = 0; chg_cnt = 0;
        while (c < 1000 && done_cnt == 0) begin
            period_end = (c % 3 == 2);
            tick();
            if (done_cnt == 0 && !busy) busy_low++;
            if (busy && cmd_bus.cmd_ready) ready_busy++;
            c++;
        end
        period_end = 1'b0;
        check({tag, "_done_reached"}, 32'(done_cnt > 0), 1);
        check({tag, "_final_duty"}, duty_cycle, final_v);
        check({tag, "_steps"}, chg_cnt, exp_steps);
        check({tag, "_pulses"}, pe_cnt, exp_pulses);
        check({tag, "_busy_throughout"}, busy_low, 0);
        check({tag, "_ready_while_busy"}, ready_busy, 0);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_until_duty(input int val);
        int c;
        c = 0;
        while (duty_cycle != val && c < 1000) begin
            period_end = (c % 3 == 2);
            tick();
            c++;
        end
        period_end = 1'b0;
        check("reach_duty", duty_cycle, val);
    endtask

    initial begin
        vecs[0] = '{cmd: 8'd64,  steps: 16, pulses: 32};
        vecs[1] = '{cmd: 8'd10,  steps: 14, pulses: 28};
        vecs[2] = '{cmd: 8'd250, steps: 60, pulses: 120};
        vecs[3] = '{cmd: 8'd255, steps: 2,  pulses: 4};
        vecs[4] = '{cmd: 8'd3,   steps: 63, pulses: 126};
        vecs[5] = '{cmd: 8'd0,   steps: 1,  pulses: 2};

        reset = 1'b1; period_end = 1'b0; kill = 1'b0;
        cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_duty = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_duty", duty_cycle, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_bus.cmd_ready, 1);
        reset = 1'b0;
        idle_ticks(2);

        // Chained ramps: up, down with partial last step, top without wrap, to zero.
        for (int i = 0; i < 6; i++) begin
            push_ramp(prev_duty, vecs[i].cmd);
            send_cmd(vecs[i].cmd);
            run_ramp(vecs[i].cmd, vecs[i].steps, vecs[i].pulses, "ramp");
            idle_ticks(3);
            check("ramp_done_single", done_cnt, 1);
            check("ramp_idle_after", busy, 0);
        end

        // Kill mid-UP at duty 40.
        push_ramp(0, 64);
        send_cmd(8'd64);
        run_until_duty(40);
        kill = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'd0);
        done_cnt = 0;
        tick();
        check("kill_duty", duty_cycle, 0);
        check("kill_busy", busy, 0);
        check("kill_ready", cmd_bus.cmd_ready, 0);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty  = 8'd50;
        for (int i = 0; i < 6; i++) begin
            period_end = (i % 3 == 2);
            tick();
        end
        period_end = 1'b0;
        check("kill_ready_held", cmd_bus.cmd_ready, 0);
        check("kill_busy_held", busy, 0);
        cmd_bus.cmd_valid = 1'b0;
        kill = 1'b0;
        tick();
        check("kill_no_done", done_cnt, 0);
        check("kill_ready_release", cmd_bus.cmd_ready, 1);
        push_ramp(0, 8);
        send_cmd(8'd8);
        run_ramp(8, 2, 4, "after_kill");

        // A command offered while busy waits until the ramp is finished.
        push_ramp(8, 20);
        send_cmd(8'd20);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty  = 8'd24;
        run_ramp(20, 3, 6, "hold");
        push_ramp(20, 24);
        tick();
        check("hold_accept_busy", busy, 1);
        cmd_bus.cmd_valid = 1'b0;
        run_ramp(24, 1, 2, "held_cmd");

        // Command equal to current duty: done only, no ramp.
        send_cmd(8'd24);
        check("eq_done", done, 1);
        check("eq_busy", busy, 0);
        check("eq_duty", duty_cycle, 24);
        done_cnt = 0;
        tick();
        check("eq_done_clears", done, 0);
        for (int i = 0; i < 6; i++) begin
            period_end = (i % 2 == 0);
            tick();
        end
        period_end = 1'b0;
        check("idle_pe_duty", duty_cycle, 24);
        check("idle_pe_busy", busy, 0);
        check("idle_pe_done", done_cnt, 0);

        // Accept coincident with period_end: that pulse must not count.
        push_ramp(24, 32);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty  = 8'd32;
        period_end        = 1'b1;
        tick();
        period_end        = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        run_ramp(32, 2, 4, "coincident");

        // Asynchronous reset between clock edges mid-ramp.
        push_ramp(32, 100);
        send_cmd(8'd100);
        run_until_duty(48);
        #2 reset = 1'b1;
        #1;
        check("areset_duty", duty_cycle, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_ready", cmd_bus.cmd_ready, 1);
        #2 reset = 1'b0;
        exp_q.delete();
        prev_duty = 8'd0;
        done_cnt  = 0;
        for (int i = 0; i < 9; i++) begin
            period_end = (i % 3 == 2);
            tick();
        end
        period_end = 1'b0;
        check("post_reset_duty", duty_cycle, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
